// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite protocol encodings used by masters, slaves and interconnect.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package ahb3lite_pkg;

  // Transfer type
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Transfer size
  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  // Burst type
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  // Slave response
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb3lite_master_bridge.sv
// Native req/gnt to AHB3-Lite single-transfer master, up to one address and one data phase in flight.
// Latency: gnt in cycle N -> NONSEQ in N+1 -> data phase N+2 -> rsp_valid_o in N+3 with zero wait states.
// Backpressure: HREADY=0 stalls both phases and drops gnt_o; two-cycle ERROR replays the pending address phase.
module ahb3lite_master_bridge
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,

  // Native request side
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [HADDR_SIZE-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  logic [HDATA_SIZE-1:0] wdata_i,

  // Native completion side
  output logic                  rsp_valid_o,
  output logic                  rsp_err_o,
  output logic [HDATA_SIZE-1:0] rsp_rdata_o,

  // AHB master outputs
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,

  // AHB master inputs
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  // Data access, privileged, non-bufferable, non-cacheable
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_NONSEQ = 2'd1,
    A_ERR    = 2'd2
  } astate_t;

  astate_t                 state, state_nxt;
  logic                    gnt;
  logic                    addr_acc;     // address phase accepted into the data phase
  logic [HDATA_SIZE-1:0]   pend_wdata;   // write data waiting for its data phase
  logic                    dp_vld;
  logic                    dp_write;
  logic                    dp_done;

  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA_PRIV;
  assign HMASTLOCK = 1'b0;
  assign gnt_o     = gnt;
  assign dp_done   = dp_vld & HREADY;

  // Address-phase state register
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= A_IDLE;
    else        state <= state_nxt;
  end

  // Next state, grant and transfer type
  always_comb begin
    state_nxt = state;
    gnt       = 1'b0;
    addr_acc  = 1'b0;
    HTRANS    = HTRANS_IDLE;
    case (state)
      A_IDLE: begin
        gnt = req_i & ~HRESET;
        if (gnt) state_nxt = A_NONSEQ;
      end
      A_NONSEQ: begin
        HTRANS = HRESET ? HTRANS_IDLE : HTRANS_NONSEQ;
        if (HREADY) begin
          addr_acc  = 1'b1;
          gnt       = req_i & ~HRESET;
          state_nxt = gnt ? A_NONSEQ : A_IDLE;
        end else if (dp_vld && HRESP == HRESP_ERROR) begin
          // First error cycle: withdraw the pending NONSEQ, replay it afterwards
          state_nxt = A_ERR;
        end
      end
      A_ERR: begin
        if (HREADY) state_nxt = A_NONSEQ;
      end
      default: state_nxt = A_IDLE;
    endcase
  end

  // Capture a granted request into the address phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HADDR      <= '0;
      HWRITE     <= 1'b0;
      HSIZE      <= 3'b000;
      pend_wdata <= '0;
    end else if (gnt) begin
      HADDR      <= addr_i;
      HWRITE     <= we_i;
      HSIZE      <= size_i;
      pend_wdata <= wdata_i;
    end
  end

  // Data-phase tracking; HWDATA only changes when a new data phase starts
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_vld   <= 1'b0;
      dp_write <= 1'b0;
      HWDATA   <= '0;
    end else if (addr_acc) begin
      dp_vld   <= 1'b1;
      dp_write <= HWRITE;
      HWDATA   <= pend_wdata;
    end else if (HREADY) begin
      dp_vld   <= 1'b0;
    end
  end

  // One-cycle completion pulse after the data phase ends
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      rsp_valid_o <= dp_done;
      rsp_err_o   <= dp_done & (HRESP == HRESP_ERROR);
      rsp_rdata_o <= (dp_done & ~dp_write) ? HRDATA : '0;
    end
  end

endmodule
